// File: rtl/paula_floppy_dma_rd_pkg.sv
// rtl/paula_floppy_dma_rd_pkg.sv - shared state encoding and DSKLEN field positions for the disk read DMA path
package paula_floppy_dma_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_SYNC  = 3'd2,
        ST_XFER  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DSKLEN_DMAEN   = 15;
    localparam int DSKLEN_WRITE   = 14;
    localparam int DSKLEN_LEN_MSB = 13;

    // A DSKLEN write that requests a read transfer (DMA on, direction read)
    function automatic logic is_read_go(input logic [15:0] v);
        return v[DSKLEN_DMAEN] && !v[DSKLEN_WRITE];
    endfunction

endpackage

// File: rtl/paula_floppy_dma_hold.sv
// rtl/paula_floppy_dma_hold.sv - single-entry word hold register presenting a req/ack handshake
module paula_floppy_dma_hold (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic        clear,
    input  logic        allow,
    input  logic        ack,
    output logic        req,
    output logic [15:0] data,
    output logic        empty,
    output logic        xfer
);

    logic        full;
    logic [15:0] word;

    // allow gates the request so a paused channel never hands a word over
    assign req   = full & allow;
    assign data  = word;
    assign empty = ~full;
    assign xfer  = en & req & ack & ~clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            word <= 16'h0000;
        end else if (en) begin
            if (clear) begin
                full <= 1'b0;
                word <= 16'h0000;
            end else if (load) begin
                full <= 1'b1;
                word <= load_data;
            end else if (xfer) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/paula_floppy_dma_rd.sv
// rtl/paula_floppy_dma_rd.sv - floppy FIFO to chip-bus read DMA with DSKSYNC hunt and block interrupts
module paula_floppy_dma_rd
    import paula_floppy_dma_rd_pkg::*;
#(
    parameter int LEN_W = 14
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk7_en,
    input  logic             dsklen_wr,
    input  logic [15:0]      dsklen_data,
    input  logic [15:0]      dsksync,
    input  logic             wordsync,
    input  logic             dmaen,
    input  logic [15:0]      fifo_out,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    output logic             dma_req,
    output logic [15:0]      dma_data,
    input  logic             dma_ack,
    output logic             busy,
    output logic             int_syn,
    output logic             int_blk,
    output logic [LEN_W-1:0] words_left
);

    state_t           state;
    logic             pop_prev;
    logic             hold_empty;
    logic             hold_xfer;
    logic             abort;
    logic             go;
    logic             active;
    logic             match;
    logic [LEN_W-1:0] len;

    assign abort  = clk7_en & dsklen_wr & ~dsklen_data[DSKLEN_DMAEN];
    assign go     = dsklen_wr & is_read_go(dsklen_data);
    assign len    = dsklen_data[DSKLEN_LEN_MSB -: LEN_W];
    assign active = (state == ST_SYNC) || (state == ST_XFER);
    assign match  = (fifo_out == dsksync);
    assign busy   = (state != ST_IDLE) && (state != ST_ARMED);

    // Pops are spaced by one enable cycle so the FIFO's registered output and empty flag settle
    assign fifo_rd = clk7_en & active & hold_empty & ~fifo_empty & dmaen & ~pop_prev & ~abort;

    paula_floppy_dma_hold u_hold (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (clk7_en),
        .load      (fifo_rd && (state == ST_XFER)),
        .load_data (fifo_out),
        .clear     (abort),
        .allow     (dmaen),
        .ack       (dma_ack),
        .req       (dma_req),
        .data      (dma_data),
        .empty     (hold_empty),
        .xfer      (hold_xfer)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            words_left <= '0;
            pop_prev   <= 1'b0;
            int_syn    <= 1'b0;
            int_blk    <= 1'b0;
        end else if (clk7_en) begin
            pop_prev <= fifo_rd;
            int_syn  <= 1'b0;
            int_blk  <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (go) state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (go) begin
                            words_left <= len;
                            if (len == '0)    state <= ST_DONE;
                            else if (wordsync) state <= ST_SYNC;
                            else               state <= ST_XFER;
                        end else if (dsklen_wr) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_SYNC: begin
                        // The sync word itself is consumed here and never reaches the hold register
                        if (fifo_rd && match) begin
                            int_syn <= 1'b1;
                            state   <= ST_XFER;
                        end
                    end
                    ST_XFER: begin
                        if (fifo_rd && wordsync && match) int_syn <= 1'b1;
                        if (hold_xfer) begin
                            words_left <= words_left - LEN_W'(1);
                            if (words_left == LEN_W'(1)) state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        int_blk <= 1'b1;
                        state   <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_paula_floppy_dma_rd.sv
// tb/tb_paula_floppy_dma_rd.sv - self-checking bench for the floppy read DMA block
module tb_paula_floppy_dma_rd;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk7_en;
    logic        dsklen_wr;
    logic [15:0] dsklen_data;
    logic [15:0] dsksync;
    logic        wordsync;
    logic        dmaen;
    logic [15:0] fifo_out;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        dma_req;
    logic [15:0] dma_data;
    logic        dma_ack;
    logic        busy;
    logic        int_syn;
    logic        int_blk;
    logic [13:0] words_left;

    always #5 clk = ~clk;

    paula_floppy_dma_rd #(.LEN_W(14)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk7_en     (clk7_en),
        .dsklen_wr   (dsklen_wr),
        .dsklen_data (dsklen_data),
        .dsksync     (dsksync),
        .wordsync    (wordsync),
        .dmaen       (dmaen),
        .fifo_out    (fifo_out),
        .fifo_empty  (fifo_empty),
        .fifo_rd     (fifo_rd),
        .dma_req     (dma_req),
        .dma_data    (dma_data),
        .dma_ack     (dma_ack),
        .busy        (busy),
        .int_syn     (int_syn),
        .int_blk     (int_blk),
        .words_left  (words_left)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] fq[$];
    logic [15:0] xq[$];
    int pop_cnt, consec_cnt, under_cnt, syn_cnt, blk_cnt, req_cnt, busy_cnt, unstable_cnt;
    logic last_pop, prev_req, prev_xfer;
    logic [15:0] prev_data;

    bit   en_rand = 0, ack_rand = 0, dmaen_rand = 0;
    logic ack_man = 1'b0, dmaen_man = 1'b1;

    initial begin
        clk7_en = 1'b1;
        dma_ack = 1'b0;
        dmaen   = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            clk7_en = en_rand    ? ($urandom_range(0, 3) != 0) : 1'b1;
            dma_ack = ack_rand   ? 1'($urandom_range(0, 1))    : ack_man;
            dmaen   = dmaen_rand ? ($urandom_range(0, 9) != 0) : dmaen_man;
        end
    end

    // Observer samples just before each rising edge; the FIFO model advances just after it
    initial begin
        fifo_out   = 16'h0000;
        fifo_empty = 1'b1;
        last_pop   = 1'b0;
        prev_req   = 1'b0;
        prev_xfer  = 1'b0;
        prev_data  = 16'h0000;
        forever begin
            @(negedge clk);
            #4;
            if (reset_n) begin
                if (fifo_rd) begin
                    pop_cnt++;
                    if (fifo_empty) under_cnt++;
                    else if (fq.size() > 0) void'(fq.pop_front());
                end
                if (clk7_en) begin
                    if (fifo_rd && last_pop) consec_cnt++;
                    last_pop = fifo_rd;
                    if (int_syn) syn_cnt++;
                    if (int_blk) blk_cnt++;
                end
                if (dma_req) req_cnt++;
                if (busy) busy_cnt++;
                if (prev_req && !prev_xfer && dma_req && dma_data !== prev_data) unstable_cnt++;
                prev_xfer = clk7_en && dma_req && dma_ack;
                if (prev_xfer) xq.push_back(dma_data);
                prev_req  = dma_req;
                prev_data = dma_data;
            end else begin
                last_pop = 1'b0;
                prev_req = 1'b0;
            end
            #2;
            fifo_empty = (fq.size() == 0);
            fifo_out   = fifo_empty ? 16'h0000 : fq[0];
        end
    end

    task automatic clear_mon();
        pop_cnt = 0; consec_cnt = 0; under_cnt = 0; syn_cnt = 0;
        blk_cnt = 0; req_cnt = 0; busy_cnt = 0; unstable_cnt = 0;
        xq.delete();
    endtask

    task automatic dsk_write(input logic [15:0] v);
        @(negedge clk);
        dsklen_wr   = 1'b1;
        dsklen_data = v;
        @(negedge clk);
        dsklen_wr   = 1'b0;
    endtask

    task automatic wait_blk(input int budget, output bit ok);
        int n = 0;
        int start = blk_cnt;
        while (blk_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (blk_cnt != start);
    endtask

    function automatic bit same_q(input logic [15:0] a[$], input logic [15:0] b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] !== b[i]) return 0;
        return 1;
    endfunction

    function automatic logic [15:0] rand_not(input logic [15:0] s);
        logic [15:0] w;
        do w = 16'($urandom); while (w == s);
        return w;
    endfunction

    task automatic test_reset();
        checks++;
        if ({fifo_rd, dma_req, dma_data, busy, int_syn, int_blk, words_left} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b data=%h busy=%b syn=%b blk=%b wl=%0d rd=%b, want all 0",
                     dma_req, dma_data, busy, int_syn, int_blk, words_left, fifo_rd);
        end
    endtask

    task automatic test_basic();
        logic [15:0] want[$];
        bit ok;
        clear_mon();
        want = '{16'h1111, 16'h2222, 16'h3333};
        fq = want;
        wordsync = 1'b0; ack_man = 1'b1;
        dsk_write(16'h8003);
        dsk_write(16'h8003);
        wait_blk(200, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done: int_blk never seen, want pulse"); end
        checks++; if (!same_q(xq, want)) begin errors++; $display("FAIL basic_data: got %p want %p", xq, want); end
        checks++; if (consec_cnt != 0) begin errors++; $display("FAIL basic_cadence: back-to-back pops %0d, want 0", consec_cnt); end
        checks++; if (blk_cnt != 1) begin errors++; $display("FAIL basic_blk: %0d pulses, want 1", blk_cnt); end
        checks++; if (syn_cnt != 0) begin errors++; $display("FAIL basic_syn: %0d pulses, want 0", syn_cnt); end
        checks++; if (words_left !== 14'd0) begin errors++; $display("FAIL basic_left: %0d, want 0", words_left); end
        checks++; if (under_cnt != 0) begin errors++; $display("FAIL basic_underflow: %0d, want 0", under_cnt); end
    endtask

    task automatic test_sync();
        logic [15:0] want[$];
        bit ok;
        clear_mon();
        fq = '{16'hAAAA, 16'h4489, 16'h5555, 16'h6666};
        want = '{16'h5555, 16'h6666};
        wordsync = 1'b1; dsksync = 16'h4489; ack_man = 1'b1;
        dsk_write(16'h8002);
        dsk_write(16'h8002);
        wait_blk(200, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL sync_done: int_blk never seen, want pulse"); end
        checks++; if (!same_q(xq, want)) begin errors++; $display("FAIL sync_data: got %p want %p", xq, want); end
        checks++; if (syn_cnt != 1) begin errors++; $display("FAIL sync_syn: %0d pulses, want 1", syn_cnt); end
        checks++; if (blk_cnt != 1) begin errors++; $display("FAIL sync_blk: %0d pulses, want 1", blk_cnt); end
        wordsync = 1'b0;
        fq.delete();
    endtask

    task automatic test_arm_abort();
        bit ok;
        clear_mon();
        fq = '{16'h1234, 16'h5678};
        wordsync = 1'b0; ack_man = 1'b1;
        dsk_write(16'h8004);
        dsk_write(16'h0000);
        dsk_write(16'h8004);
        repeat (4) @(negedge clk);
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL arm_busy: busy for %0d cycles, want 0", busy_cnt); end
        checks++; if (pop_cnt != 0 || xq.size() != 0) begin errors++; $display("FAIL arm_notransfer: pops %0d xfers %0d, want 0 0", pop_cnt, xq.size()); end
        clear_mon();
        dsk_write(16'h8000);
        wait_blk(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL arm_state: no int_blk after length-0 write, want pulse (ARMED)"); end
        checks++; if (req_cnt != 0) begin errors++; $display("FAIL arm_noreq: dma_req for %0d cycles, want 0", req_cnt); end
        repeat (2) @(negedge clk);
        fq.delete();
    endtask

    task automatic test_stall();
        logic [15:0] w0;
        int n = 0;
        clear_mon();
        w0 = 16'($urandom);
        fq = '{w0, 16'($urandom), 16'($urandom), 16'($urandom)};
        wordsync = 1'b0; ack_man = 1'b0;
        dsk_write(16'h8004);
        dsk_write(16'h8004);
        while (!dma_req && n < 20) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        checks++; if (dma_req !== 1'b1 || dma_data !== w0) begin errors++; $display("FAIL stall_req: req=%b data=%h, want 1 %h", dma_req, dma_data, w0); end
        checks++; if (unstable_cnt != 0) begin errors++; $display("FAIL stall_stable: data changed %0d times, want 0", unstable_cnt); end
        checks++; if (pop_cnt != 1) begin errors++; $display("FAIL stall_pops: %0d, want 1", pop_cnt); end
        checks++; if (words_left !== 14'd4) begin errors++; $display("FAIL stall_left: %0d, want 4", words_left); end
        dsk_write(16'h0000);
        repeat (2) @(negedge clk);
        fq.delete();
    endtask

    task automatic test_abort();
        logic [15:0] all[$];
        logic [15:0] want[$];
        int n = 0;
        clear_mon();
        for (int i = 0; i < 8; i++) all.push_back(16'($urandom));
        fq = all;
        want = all[0:2];
        wordsync = 1'b0; ack_man = 1'b1;
        dsk_write(16'h8008);
        dsk_write(16'h8008);
        while (xq.size() < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (xq.size() >= 3) ack_man = 1'b0;
        end
        @(negedge clk);
        checks++; if (words_left !== 14'd5) begin errors++; $display("FAIL abort_left: %0d, want 5", words_left); end
        dsk_write(16'h0000);
        checks++; if (dma_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_drop: req=%b busy=%b, want 0 0", dma_req, busy); end
        repeat (6) @(negedge clk);
        checks++; if (blk_cnt != 0) begin errors++; $display("FAIL abort_noblk: %0d pulses, want 0", blk_cnt); end
        checks++; if (!same_q(xq, want)) begin errors++; $display("FAIL abort_data: got %p want %p", xq, want); end
        fq.delete();
    endtask

    task automatic test_pause();
        logic [15:0] all[$];
        int n = 0;
        int pops;
        int xs;
        bit ok;
        clear_mon();
        for (int i = 0; i < 3; i++) all.push_back(16'($urandom));
        fq = all;
        wordsync = 1'b0; ack_man = 1'b1;
        dsk_write(16'h8003);
        dsk_write(16'h8003);
        while (xq.size() < 1 && n < 50) begin @(negedge clk); n++; end
        dmaen_man = 1'b0;
        @(negedge clk);
        pops = pop_cnt;
        xs = xq.size();
        repeat (8) @(negedge clk);
        checks++; if (dma_req !== 1'b0) begin errors++; $display("FAIL pause_req: %b, want 0", dma_req); end
        checks++; if (pop_cnt != pops || xq.size() != xs) begin errors++; $display("FAIL pause_frozen: pops %0d xfers %0d, want %0d %0d", pop_cnt, xq.size(), pops, xs); end
        checks++; if (words_left !== 14'(3 - xs)) begin errors++; $display("FAIL pause_left: %0d, want %0d", words_left, 3 - xs); end
        dmaen_man = 1'b1;
        wait_blk(200, ok);
        checks++; if (!ok || !same_q(xq, all)) begin errors++; $display("FAIL pause_resume: done=%b got %p want %p", ok, xq, all); end
        repeat (2) @(negedge clk);
        fq.delete();
    endtask

    task automatic test_async_reset();
        int n = 0;
        bit ok;
        clear_mon();
        for (int i = 0; i < 6; i++) fq.push_back(16'($urandom));
        wordsync = 1'b0; ack_man = 1'b1;
        dsk_write(16'h8006);
        dsk_write(16'h8006);
        while (xq.size() < 2 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({fifo_rd, dma_req, dma_data, busy, int_syn, int_blk, words_left} !== '0) begin
            errors++;
            $display("FAIL async_reset: got req=%b data=%h busy=%b wl=%0d, want all 0", dma_req, dma_data, busy, words_left);
        end
        @(negedge clk);
        reset_n = 1'b1;
        fq.delete();
        clear_mon();
        dsk_write(16'h8000);
        dsk_write(16'h8000);
        wait_blk(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_len0_blk: no int_blk, want pulse"); end
        checks++; if (req_cnt != 0) begin errors++; $display("FAIL reset_len0_req: dma_req %0d cycles, want 0", req_cnt); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [15:0] sync;
            logic [15:0] data[$];
            logic [15:0] want[$];
            int len;
            int want_syn;
            bit ws;
            bit ok;
            clear_mon();
            fq.delete();
            sync = 16'($urandom);
            len = $urandom_range(1, 8);
            ws = 1'($urandom_range(0, 1));
            if (ws) begin
                repeat ($urandom_range(0, 3)) fq.push_back(rand_not(sync));
                fq.push_back(sync);
            end
            for (int i = 0; i < len + 2; i++)
                data.push_back(($urandom_range(0, 4) == 0) ? sync : rand_not(sync));
            foreach (data[i]) fq.push_back(data[i]);
            want = data[0:len-1];
            want_syn = 0;
            if (ws) begin
                want_syn = 1;
                foreach (want[i]) if (want[i] == sync) want_syn++;
            end
            dsksync = sync; wordsync = ws;
            dsk_write(16'h8000 | 16'(len));
            dsk_write(16'h8000 | 16'(len));
            en_rand = 1; ack_rand = 1; dmaen_rand = 1;
            wait_blk(3000, ok);
            en_rand = 0; ack_rand = 0; dmaen_rand = 0;
            repeat (3) @(negedge clk);
            checks++; if (!ok || !same_q(xq, want)) begin errors++; $display("FAIL rand%0d_data: done=%b got %p want %p", it, ok, xq, want); end
            checks++; if (syn_cnt != want_syn || blk_cnt != 1) begin errors++; $display("FAIL rand%0d_ints: syn %0d blk %0d, want %0d 1", it, syn_cnt, blk_cnt, want_syn); end
            checks++;
            if (consec_cnt != 0 || under_cnt != 0 || unstable_cnt != 0 || words_left !== 14'd0) begin
                errors++;
                $display("FAIL rand%0d_rules: consec %0d under %0d unstable %0d wl %0d, want 0 0 0 0", it, consec_cnt, under_cnt, unstable_cnt, words_left);
            end
        end
        wordsync = 1'b0;
        fq.delete();
    endtask

    initial begin
        reset_n     = 1'b0;
        dsklen_wr   = 1'b0;
        dsklen_data = 16'h0000;
        dsksync     = 16'h4489;
        wordsync    = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_sync();
        test_arm_abort();
        test_stall();
        test_abort();
        test_pause();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/paula_floppy_dma_rd.md
Name: paula_floppy_dma_rd

Overview:
Downstream consumer of the floppy word FIFO. It pops MFM words from the FIFO, optionally hunts for the DSKSYNC word, and delivers DSKLEN words to the chip-bus DMA slot through a req/ack handshake. It raises the DSKSYN and DSKBLK interrupt pulses and sits between the floppy FIFO and the Agnus disk DMA slot logic.

Parameters:
LEN_W, 14, width of the DSKLEN word counter (DSKLEN[13:0])

Ports:
clk  in  1  bus clock
reset_n  in  1  asynchronous active-low reset
clk7_en  in  1  clock enable; all state advances only when high
dsklen_wr  in  1  one-enable-cycle strobe: DSKLEN register write
dsklen_data  in  16  DSKLEN value ([15]=DMAEN, [14]=WRITE, [13:0]=length)
dsksync  in  16  sync word (DSKSYNC register)
wordsync  in  1  ADKCON WORDSYNC: 1 = wait for sync before transfer
dmaen  in  1  DMACON master and disk enable; 0 = pause
fifo_out  in  16  FIFO output word
fifo_empty  in  1  FIFO empty flag
fifo_rd  out  1  FIFO pop strobe
dma_req  out  1  word pending for chip RAM
dma_data  out  16  word being delivered
dma_ack  in  1  DMA slot accepted dma_data
busy  out  1  state is not IDLE or ARMED
int_syn  out  1  one-enable-cycle pulse: sync word matched
int_blk  out  1  one-enable-cycle pulse: block complete
words_left  out  LEN_W  remaining word count

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; hold register is empty.
- States are IDLE, ARMED, SYNC, XFER and DONE. All transitions are qualified by clk7_en.
- IDLE: a dsklen_wr with [15]=1 and [14]=0 moves to ARMED.
- ARMED: a second consecutive dsklen_wr with [15]=1 and [14]=0 latches the length into words_left.
  - If wordsync=1, go to SYNC; otherwise go to XFER.
  - If the latched length is 0, go directly to DONE.
  - Any other dsklen_wr returns to IDLE.
- dsklen_wr with [15]=0 in any state aborts to IDLE the next cycle.
  - No interrupt is raised.
  - dma_req drops and the hold register is cleared.
- Pop cadence:
  - fifo_rd=1 for one enable cycle only when all of these hold: state is SYNC or XFER, the hold register is empty, fifo_empty=0, dmaen=1, and no pop occurred in the previous enable cycle.
  - The skipped cycle covers the FIFO's registered output and delayed empty flag.
  - The word is captured from fifo_out in the same enable cycle fifo_rd=1.
- SYNC: each popped word is compared with dsksync.
  - On mismatch, the word is discarded.
  - On match, int_syn pulses the next cycle and the state moves to XFER. The sync word itself is not transferred.
- XFER: a popped word loads the hold register, and dma_req=1 with dma_data set to the held word.
  - A transfer occurs on an enable cycle with dma_req=1 and dma_ack=1. On a transfer the hold register empties and words_left decrements.
  - When words_left goes 1 to 0, move to DONE.
  - dma_data must stay stable while dma_req=1.
- In XFER with wordsync=1, popped words matching dsksync still pulse int_syn and are transferred.
- dmaen=0: dma_req is forced to 0 and no pops occur. State, hold register and words_left are held, and operation resumes when dmaen returns to 1.
- DONE: int_blk pulses for one enable cycle, then the state returns to IDLE. A new double write is required to restart.
- Simultaneous events:
  - dma_ack together with an abort: the transfer is not counted, and words_left is irrelevant after the abort.
  - A pop and a transfer cannot coincide, because a pop requires the hold register to be empty.
- No FIFO underflow: fifo_rd is never asserted while fifo_empty=1.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=0, ARMED=1, SYNC=2, XFER=3, DONE=4
  - DSKLEN bit indices: DMAEN=15, WRITE=14, LEN msb=13
- One sub-module is natural: paula_floppy_dma_hold, a single-entry hold register with req/ack and empty flag.
- The FSM, counter and sync comparator stay in the top module.

Test Plan:
- Two writes of 16'h8003, wordsync=0, FIFO preloaded with 16'h1111, 16'h2222, 16'h3333, dma_ack always 1 -> dma_data 1111, 2222, 3333 in order; fifo_rd never on consecutive enable cycles; int_blk pulses once; words_left=0; int_syn never pulses.
- wordsync=1, dsksync=16'h4489, FIFO holds AAAA, 4489, 5555, 6666, length 2 -> AAAA and 4489 are not transferred; int_syn pulses once; 5555 and 6666 are delivered; int_blk pulses.
- A single write of 16'h8004, then 16'h0000, then 16'h8004 -> no transfer; busy stays 0; the state is back in ARMED after the last write.
- Length 4 with dma_ack held 0 for 10 cycles -> dma_req stays 1 and dma_data stays stable; only one fifo_rd is issued; words_left stays 4.
- Mid-transfer (words_left=5), write 16'h0000 -> dma_req drops the next cycle; no int_blk; busy=0. Separately, dmaen=0 mid-transfer -> outputs freeze, and the transfer completes after re-enable.
- Drive reset_n low asynchronously mid-XFER -> all outputs go to 0 immediately, without waiting for clk; the length 0 double write afterwards yields int_blk with no dma_req.
